exec_unit_p: RTL
================

Name: exec_unit_p

Overview:
- Parametrised, handshaked successor to the single-cycle CPU execute stage.
- Contains register file, NZCV flags, ALU, condition evaluator, word-addressed data memory and GPIO output register.
- Sits between Decode and Fetch. Takes one decoded micro-op per accepted handshake.
- Adds over the previous generation: multi-cycle loads with back-pressure, a configurable branch-shadow squash count, and width/depth generics.

Parameters:
- DATA_W, 32, datapath and register width.
- NUM_REGS, 16, register count; RA_W = $clog2(NUM_REGS).
- DMEM_DEPTH, 32, data-memory words (power of two); DA_W = $clog2(DMEM_DEPTH).
- GPIO_W, 32, GPIO output width (≤ DATA_W).
- LOAD_LAT, 2, cycles a load occupies after acceptance (≥1).
- SQUASH_N, 1, accepted instructions discarded after a taken branch (≥0).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  Decode presents a micro-op.
- in_ready  out  1  unit can accept this cycle.
- op  in  3  0 NOP, 1 ALU, 2 LOAD, 3 STORE, 4 GPIO_WR, 5 GPIO_RD, 6 BRANCH.
- alu_op  in  3  0 ADD, 1 SUB, 2 AND, 3 ORR, 4 EOR, 5 MOV(rhs), 6 CMP(SUB, no writeback).
- set_flags  in  1  ALU op updates NZCV (CMP always does).
- num_to_rhs  in  1  rhs = num instead of reg[sel_p0].
- num  in  DATA_W  immediate / branch offset.
- sel_p0, sel_p1, sel_in  in  RA_W  rhs reg, lhs reg, destination reg.
- branch_cond  in  4  ARM condition code (EQ..LE, 14 = AL, 15 = never).
- branch_taken  out  1  one-cycle pulse on a taken branch.
- branch_delta  out  DATA_W  num of the taken branch, 0 otherwise.
- gpio_state  out  GPIO_W  GPIO register.

Behaviour:
- Accept = in_valid & in_ready. Nothing changes state unless an instruction is accepted or pending.
- Reset (async): registers, NZCV, gpio_state, branch_taken, branch_delta = 0; squash count = 0; state READY; in_ready = 1. Dmem is not reset.
- Operand reads are combinational and see all writes committed on earlier edges.
- lhs = reg[sel_p1]. rhs = num_to_rhs ? num : reg[sel_p0].
- Arithmetic is modulo 2^DATA_W.
- ADD flags: C = carry out, V = signed overflow.
- SUB/CMP flags: C = NOT borrow (ARM), V = signed overflow.
- Logic and MOV flags: N and Z from the result; C and V are unchanged.
- FSM state READY:
  - ALU: writes reg[sel_in] (except CMP) and flags on the accept edge. Latency 1.
  - STORE: dmem[alu(ADD)[DA_W-1:0]] <= reg[sel_p0] on the accept edge.
  - GPIO_WR: gpio_state <= reg[sel_p0][GPIO_W-1:0].
  - GPIO_RD: reg[sel_in] <= zero-extended gpio_state.
  - LOAD: latches address and destination, then goes to LOAD_WAIT with counter = LOAD_LAT-1 and in_ready = 0. If LOAD_LAT = 1, the writeback happens on the accept edge and the state stays READY.
- FSM state LOAD_WAIT:
  - Counter decrements each cycle.
  - On the edge where it reaches 0: reg[dest] <= dmem[addr], state returns to READY, in_ready = 1 the following cycle.
  - Load-to-use spacing is therefore LOAD_LAT cycles.
- Memory addresses are wrap-around: only the low DA_W bits of the computed address are used.
- BRANCH:
  - Condition is evaluated against the flags as committed before the accept edge.
  - If taken: branch_taken = 1 and branch_delta = num for exactly the next cycle, and the squash count is loaded with SQUASH_N.
  - If not taken: no outputs change.
- Squash:
  - While the squash count > 0, each accepted instruction is discarded (no register, flag, memory or GPIO effect, no branch) and the count decrements.
  - A squashed LOAD does not enter LOAD_WAIT.
  - A squashed BRANCH does not reload the count.
- NOP: accepted and has no effect, but still consumes a squash slot.
- Writing reg[x] and reading reg[x] in the same cycle: the read returns the old value.
- Reset asserted during LOAD_WAIT aborts the load with no writeback and forces READY.

Test Plan:
- Reset, then ALU MOV num=5 to r1, then ADD r2 = r1 + 3 imm -> r2 = 8, NZCV = 0000 (set_flags = 1), in_ready stays 1 throughout.
- r1 = 0x7FFFFFFF, ADD imm 1 with flags -> r = 0x80000000, N = 1, V = 1, C = 0, Z = 0. Then CMP r0 = 0 vs 0 -> Z = 1, C = 1, r0 unchanged.
- STORE r3 = 0xDEAD to addr 33 (wraps to 1), then LOAD from 1 with LOAD_LAT = 2 -> in_ready low for exactly 1 cycle, destination = 0xDEAD two cycles after acceptance; an in_valid held high during the wait is not accepted.
- CMP equal, then BRANCH EQ num = -4, then ALU MOV r5 = 9 -> branch_taken pulses 1 cycle with delta 0xFFFFFFFC, and r5 remains 0 (squashed, SQUASH_N = 1). Repeat with cond NE -> no pulse, r5 = 9.
- GPIO_WR r6 = 0xA5, then GPIO_RD to r7 -> gpio_state = 0xA5 next cycle, r7 = 0xA5.
- Issue LOAD, assert rst one cycle into LOAD_WAIT -> all registers 0, in_ready = 1 right after release, no later writeback.

Source files
------------

// File: rtl/exec_unit_p.sv
// rtl/exec_unit_p.sv - handshaked execute stage: regfile, NZCV, ALU, dmem, GPIO, branch squash
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready micro-op handshake from Decode
//   op, alu_op        operation class and ALU function
//   set_flags         ALU op updates NZCV (CMP always does)
//   num_to_rhs, num   immediate select and immediate / branch offset
//   sel_p0/p1/in      rhs register, lhs register, destination register
//   branch_cond       ARM condition code for BRANCH
//   branch_taken      one-cycle pulse on a taken branch
//   branch_delta      offset of the taken branch, 0 otherwise
//   gpio_state        GPIO output register
module exec_unit_p #(
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = 16,
    parameter int DMEM_DEPTH = 32,
    parameter int GPIO_W     = 32,
    parameter int LOAD_LAT   = 2,
    parameter int SQUASH_N   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2:0]                  op,
    input  logic [2:0]                  alu_op,
    input  logic                        set_flags,
    input  logic                        num_to_rhs,
    input  logic [DATA_W-1:0]           num,
    input  logic [$clog2(NUM_REGS)-1:0] sel_p0,
    input  logic [$clog2(NUM_REGS)-1:0] sel_p1,
    input  logic [$clog2(NUM_REGS)-1:0] sel_in,
    input  logic [3:0]                  branch_cond,
    output logic                        branch_taken,
    output logic [DATA_W-1:0]           branch_delta,
    output logic [GPIO_W-1:0]           gpio_state
);
    localparam int RA_W = $clog2(NUM_REGS);
    localparam int DA_W = $clog2(DMEM_DEPTH);
    localparam int LC_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
    localparam int SQ_W = (SQUASH_N > 0) ? $clog2(SQUASH_N + 1) : 1;

    localparam logic [2:0] OP_ALU = 3'd1, OP_LOAD = 3'd2, OP_STORE = 3'd3,
                           OP_GPIO_WR = 3'd4, OP_GPIO_RD = 3'd5, OP_BRANCH = 3'd6;
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_ORR = 3'd3,
                           ALU_EOR = 3'd4, ALU_MOV = 3'd5, ALU_CMP = 3'd6;

    typedef enum logic {S_READY, S_LOAD_WAIT} state_t;

    state_t              state_q, state_d;
    logic [LC_W-1:0]     cnt_q, cnt_d;
    logic [DA_W-1:0]     ld_addr_q, ld_addr_d;
    logic [RA_W-1:0]     ld_dest_q, ld_dest_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [3:0]          nzcv_q, nzcv_d;          // {N, Z, C, V}
    logic [GPIO_W-1:0]   gpio_q, gpio_d;
    logic                br_taken_q, br_taken_d;
    logic [DATA_W-1:0]   br_delta_q, br_delta_d;
    logic [SQ_W-1:0]     sq_q, sq_d;

    logic [DATA_W-1:0]   dmem [DMEM_DEPTH];
    logic                dmem_we;
    logic [DA_W-1:0]     dmem_wa;
    logic [DATA_W-1:0]   dmem_wd;

    logic                accept, squash, cond_pass;
    logic [DATA_W-1:0]   lhs, rhs, alu_res;
    logic [DATA_W:0]     sum, diff;
    logic [DA_W-1:0]     mem_addr;
    logic [3:0]          alu_nzcv;
    logic                alu_wb, alu_fl;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_READY;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state; a squashed LOAD never leaves READY
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_READY:     if (accept && !squash && op == OP_LOAD && LOAD_LAT > 1) state_d = S_LOAD_WAIT;
            S_LOAD_WAIT: if (cnt_q == LC_W'(1)) state_d = S_READY;
            default:     state_d = S_READY;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready = (state_q == S_READY);
    end

    assign accept       = in_valid && in_ready;
    assign squash       = (sq_q != '0);
    assign branch_taken = br_taken_q;
    assign branch_delta = br_delta_q;
    assign gpio_state   = gpio_q;

    // ALU and address generation
    always_comb begin
        lhs      = regs_q[sel_p1];
        rhs      = num_to_rhs ? num : regs_q[sel_p0];
        sum      = {1'b0, lhs} + {1'b0, rhs};
        diff     = {1'b0, lhs} - {1'b0, rhs};
        mem_addr = sum[DA_W-1:0];
        alu_res  = '0;
        alu_nzcv = nzcv_q;
        alu_wb   = 1'b1;
        alu_fl   = set_flags;
        case (alu_op)
            ALU_ADD: alu_res = sum[DATA_W-1:0];
            ALU_SUB: alu_res = diff[DATA_W-1:0];
            ALU_AND: alu_res = lhs & rhs;
            ALU_ORR: alu_res = lhs | rhs;
            ALU_EOR: alu_res = lhs ^ rhs;
            ALU_MOV: alu_res = rhs;
            ALU_CMP: begin
                alu_res = diff[DATA_W-1:0];
                alu_wb  = 1'b0;
                alu_fl  = 1'b1;
            end
            default: begin
                alu_wb = 1'b0;
                alu_fl = 1'b0;
            end
        endcase
        alu_nzcv[3] = alu_res[DATA_W-1];
        alu_nzcv[2] = (alu_res == '0);
        if (alu_op == ALU_ADD) begin
            alu_nzcv[1] = sum[DATA_W];
            alu_nzcv[0] = (lhs[DATA_W-1] == rhs[DATA_W-1]) && (sum[DATA_W-1] != lhs[DATA_W-1]);
        end else if (alu_op == ALU_SUB || alu_op == ALU_CMP) begin
            alu_nzcv[1] = ~diff[DATA_W];   // ARM carry is NOT borrow
            alu_nzcv[0] = (lhs[DATA_W-1] != rhs[DATA_W-1]) && (diff[DATA_W-1] != lhs[DATA_W-1]);
        end
    end

    // Condition evaluation against flags committed before this edge
    always_comb begin
        case (branch_cond)
            4'd0:    cond_pass = nzcv_q[2];
            4'd1:    cond_pass = !nzcv_q[2];
            4'd2:    cond_pass = nzcv_q[1];
            4'd3:    cond_pass = !nzcv_q[1];
            4'd4:    cond_pass = nzcv_q[3];
            4'd5:    cond_pass = !nzcv_q[3];
            4'd6:    cond_pass = nzcv_q[0];
            4'd7:    cond_pass = !nzcv_q[0];
            4'd8:    cond_pass = nzcv_q[1] && !nzcv_q[2];
            4'd9:    cond_pass = !nzcv_q[1] || nzcv_q[2];
            4'd10:   cond_pass = (nzcv_q[3] == nzcv_q[0]);
            4'd11:   cond_pass = (nzcv_q[3] != nzcv_q[0]);
            4'd12:   cond_pass = !nzcv_q[2] && (nzcv_q[3] == nzcv_q[0]);
            4'd13:   cond_pass = nzcv_q[2] || (nzcv_q[3] != nzcv_q[0]);
            4'd14:   cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Architectural next state
    always_comb begin
        regs_d     = regs_q;
        nzcv_d     = nzcv_q;
        gpio_d     = gpio_q;
        br_taken_d = 1'b0;
        br_delta_d = '0;
        sq_d       = sq_q;
        cnt_d      = cnt_q;
        ld_addr_d  = ld_addr_q;
        ld_dest_d  = ld_dest_q;
        dmem_we    = 1'b0;
        dmem_wa    = mem_addr;
        dmem_wd    = regs_q[sel_p0];
        if (state_q == S_LOAD_WAIT) begin
            cnt_d = cnt_q - LC_W'(1);
            if (cnt_q == LC_W'(1)) regs_d[ld_dest_q] = dmem[ld_addr_q];
        end else if (accept) begin
            if (squash) begin
                sq_d = sq_q - SQ_W'(1);
            end else begin
                case (op)
                    OP_ALU: begin
                        if (alu_wb) regs_d[sel_in] = alu_res;
                        if (alu_fl) nzcv_d = alu_nzcv;
                    end
                    OP_LOAD: begin
                        if (LOAD_LAT == 1) begin
                            regs_d[sel_in] = dmem[mem_addr];
                        end else begin
                            ld_addr_d = mem_addr;
                            ld_dest_d = sel_in;
                            cnt_d     = LC_W'(LOAD_LAT - 1);
                        end
                    end
                    OP_STORE:   dmem_we = 1'b1;
                    OP_GPIO_WR: gpio_d = regs_q[sel_p0][GPIO_W-1:0];
                    OP_GPIO_RD: regs_d[sel_in] = DATA_W'(gpio_q);
                    OP_BRANCH: begin
                        if (cond_pass) begin
                            br_taken_d = 1'b1;
                            br_delta_d = num;
                            sq_d       = SQ_W'(SQUASH_N);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            nzcv_q     <= '0;
            gpio_q     <= '0;
            br_taken_q <= 1'b0;
            br_delta_q <= '0;
            sq_q       <= '0;
            cnt_q      <= '0;
            ld_addr_q  <= '0;
            ld_dest_q  <= '0;
        end else begin
            regs_q     <= regs_d;
            nzcv_q     <= nzcv_d;
            gpio_q     <= gpio_d;
            br_taken_q <= br_taken_d;
            br_delta_q <= br_delta_d;
            sq_q       <= sq_d;
            cnt_q      <= cnt_d;
            ld_addr_q  <= ld_addr_d;
            ld_dest_q  <= ld_dest_d;
        end
    end

    // Data memory has no reset
    always_ff @(posedge clk) begin
        if (dmem_we) dmem[dmem_wa] <= dmem_wd;
    end
endmodule
